// File: rtl/nes_video_pkg.sv
// Shared definitions for the NES video pixel FIFO: frame geometry, colour width,
// writer state encoding and Gray-code helpers used by both FIFO domains.
package nes_video_pkg;

    localparam int H_PIX_DEF   = 256;
    localparam int V_LINES_DEF = 240;
    localparam int COLOR_W     = 6;

    // Helpers work on a fixed wide vector; callers zero-extend and truncate.
    // Zero upper bits leave both conversions exact for any narrower pointer.
    localparam int GRAY_MAX_W  = 16;

    typedef enum logic {
        WAIT_SOF,
        STREAM
    } wr_state_t;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin = gray;
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Two-flop synchroniser for a Gray-coded FIFO pointer from the opposite clock
// domain, with the binary equivalent of the synchronised value.
module gray_ptr_sync
    import nes_video_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_gray_sync,
    output logic [W-1:0] o_bin
);

    logic [W-1:0] r_stage1;
    logic [W-1:0] r_stage2;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stage1 <= '0;
            r_stage2 <= '0;
        end else begin
            r_stage1 <= i_gray;
            r_stage2 <= r_stage1;
        end
    end

    assign o_gray_sync = r_stage2;
    assign o_bin       = W'(gray2bin(GRAY_MAX_W'(r_stage2)));

endmodule

// File: rtl/nes_pixel_fifo_writer.sv
// Producer end of the NES dual-clock pixel FIFO: frame-aligns the PPU pixel
// stream, writes FIFO storage and publishes a Gray write pointer to the VGA side.
module nes_pixel_fifo_writer
    import nes_video_pkg::*;
#(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = COLOR_W,
    parameter int H_PIX        = H_PIX_DEF,
    parameter int V_LINES      = V_LINES_DEF,
    parameter int AFULL_MARGIN = 4
) (
    input  logic              clk_write,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_code,
    input  logic              pix_sof,
    output logic              pix_ready,
    input  logic [ADDR_W:0]   rd_ptr_gray,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic              frame_done,
    output logic              sync_err
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int X_W   = $clog2(H_PIX);
    localparam int Y_W   = $clog2(V_LINES);

    localparam logic [PTR_W-1:0] AFULL_LEVEL = PTR_W'((1 << ADDR_W) - AFULL_MARGIN);
    localparam logic [X_W-1:0]   X_LAST      = X_W'(H_PIX - 1);
    localparam logic [Y_W-1:0]   Y_LAST      = Y_W'(V_LINES - 1);

    wr_state_t         r_state;
    logic [PTR_W-1:0]  r_wr_bin;
    logic [PTR_W-1:0]  r_wr_gray;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_frame_done;
    logic              r_sync_err;

    logic [PTR_W-1:0]  w_rd_sync;
    logic [PTR_W-1:0]  w_rd_bin;
    logic [PTR_W-1:0]  w_occupancy;
    logic [PTR_W-1:0]  w_wr_bin_next;
    logic              w_full;
    logic              w_almost_full;
    logic              w_ready;
    logic              w_accept;
    logic              w_write;
    logic              w_restart;

    gray_ptr_sync #(
        .W (PTR_W)
    ) u_rd_sync (
        .i_clk       (clk_write),
        .i_reset     (reset),
        .i_gray      (rd_ptr_gray),
        .o_gray_sync (w_rd_sync),
        .o_bin       (w_rd_bin)
    );

    // The synchronised read pointer lags, so both flags can only overstate
    // occupancy; the writer may stall a little early but never overruns.
    assign w_full        = (r_wr_gray == {~w_rd_sync[ADDR_W -: 2], w_rd_sync[ADDR_W-2:0]});
    assign w_occupancy   = r_wr_bin - w_rd_bin;
    assign w_almost_full = (w_occupancy >= AFULL_LEVEL);

    // Outside a frame non-sof pixels are drained; a sof pixel waits for space.
    always_comb begin
        w_ready = 1'b0;
        if (!reset) begin
            if (r_state == STREAM) begin
                w_ready = !w_full;
            end else begin
                w_ready = !(w_full && pix_sof);
            end
        end
    end

    assign w_accept      = pix_valid && w_ready;
    assign w_write       = w_accept && ((r_state == STREAM) || pix_sof);
    assign w_restart     = (r_state == WAIT_SOF) || pix_sof;
    assign w_wr_bin_next = r_wr_bin + PTR_W'(1);

    always_ff @(posedge clk_write) begin
        if (reset) begin
            r_state      <= WAIT_SOF;
            r_wr_bin     <= '0;
            r_wr_gray    <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_mem_we     <= 1'b0;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_mem_we     <= w_write;
            r_frame_done <= 1'b0;
            if (w_write) begin
                r_mem_waddr <= r_wr_bin[ADDR_W-1:0];
                r_mem_wdata <= pix_code;
                r_wr_bin    <= w_wr_bin_next;
                r_wr_gray   <= PTR_W'(bin2gray(GRAY_MAX_W'(w_wr_bin_next)));
                if (w_restart) begin
                    // A sof inside a frame resynchronises onto the new frame.
                    if (r_state == STREAM) begin
                        r_sync_err <= 1'b1;
                    end
                    r_x     <= X_W'(1);
                    r_y     <= '0;
                    r_state <= STREAM;
                end else if (r_x == X_LAST) begin
                    r_x <= '0;
                    if (r_y == Y_LAST) begin
                        r_y          <= '0;
                        r_frame_done <= 1'b1;
                        r_state      <= WAIT_SOF;
                    end else begin
                        r_y <= r_y + Y_W'(1);
                    end
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end
        end
    end

    assign pix_ready   = w_ready;
    assign mem_we      = r_mem_we;
    assign mem_waddr   = r_mem_waddr;
    assign mem_wdata   = r_mem_wdata;
    assign wr_ptr_gray = r_wr_gray;
    assign full        = w_full;
    assign almost_full = w_almost_full;
    assign frame_done  = r_frame_done;
    assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_nes_pixel_fifo_writer.sv
// Randomised bench for the pixel FIFO writer against a frame-position /
// pointer-count reference model.
module tb_nes_pixel_fifo_writer;

    localparam int DEPTH     = 512;
    localparam int AFM       = 4;
    localparam int FRAME_PIX = 256 * 240;

    logic       clk_write = 1'b0;
    logic       reset;
    logic       pix_valid;
    logic [5:0] pix_code;
    logic       pix_sof;
    logic       pix_ready;
    logic [9:0] rd_ptr_gray;
    logic       mem_we;
    logic [8:0] mem_waddr;
    logic [5:0] mem_wdata;
    logic [9:0] wr_ptr_gray;
    logic       full;
    logic       almost_full;
    logic       frame_done;
    logic       sync_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counts of pixels written / read, frame position.
    int   m_wr;
    int   m_rd_drive;
    int   m_rd_s1;
    int   m_rd_sync;
    bit   m_in_frame;
    int   m_pos;
    bit   e_we;
    int   e_waddr;
    int   e_wdata;
    bit   e_done;
    bit   e_err;
    int   rd_mode;
    int   n_done;

    always #5 clk_write = ~clk_write;

    nes_pixel_fifo_writer dut (
        .clk_write   (clk_write),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_code    (pix_code),
        .pix_sof     (pix_sof),
        .pix_ready   (pix_ready),
        .rd_ptr_gray (rd_ptr_gray),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .wr_ptr_gray (wr_ptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .frame_done  (frame_done),
        .sync_err    (sync_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] to_gray(input int v);
        logic [9:0] b;
        b = 10'(v);
        return b ^ (b >> 1);
    endfunction

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic v, input logic s, input logic [5:0] c);
        int   occ;
        logic ex_full;
        logic ex_af;
        logic ex_ready;
        logic wr;
        pix_valid = v;
        pix_sof   = s;
        pix_code  = c;
        @(negedge clk_write);
        occ      = m_wr - m_rd_sync;
        ex_full  = (occ == DEPTH);
        ex_af    = (occ >= DEPTH - AFM);
        ex_ready = m_in_frame ? !ex_full : !(ex_full && s);
        check("pix_ready", pix_ready, ex_ready);
        check("full", full, ex_full);
        check("almost_full", almost_full, ex_af);
        wr = v && ex_ready && (m_in_frame || s);
        @(posedge clk_write);
        m_rd_sync = m_rd_s1;
        m_rd_s1   = m_rd_drive;
        e_we      = wr;
        e_done    = 1'b0;
        if (wr) begin
            e_waddr = m_wr % DEPTH;
            e_wdata = c;
            m_wr++;
            if (!m_in_frame || s) begin
                if (m_in_frame) e_err = 1'b1;
                m_in_frame = 1'b1;
                m_pos      = 1;
            end else if (m_pos == FRAME_PIX - 1) begin
                m_in_frame = 1'b0;
                m_pos      = 0;
                e_done     = 1'b1;
            end else begin
                m_pos++;
            end
        end
        #1;
        check("mem_we", mem_we, e_we);
        if (e_we) begin
            check("mem_waddr", mem_waddr, e_waddr);
            check("mem_wdata", mem_wdata, e_wdata);
        end
        check("wr_ptr_gray", wr_ptr_gray, to_gray(m_wr));
        check("frame_done", frame_done, e_done);
        check("sync_err", sync_err, e_err);
        if (frame_done) n_done++;
        if (rd_mode == 1 && m_rd_drive < m_wr) begin
            m_rd_drive++;
        end else if (rd_mode == 2 && m_rd_drive < m_wr && $urandom_range(0, 99) < 40) begin
            m_rd_drive++;
        end
        rd_ptr_gray = to_gray(m_rd_drive);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        pix_valid   = 1'b1;
        pix_sof     = 1'b1;
        pix_code    = 6'h3F;
        rd_mode     = 0;
        m_rd_drive  = 0;
        rd_ptr_gray = '0;
        repeat (3) @(posedge clk_write);
        #1;
        check("rst_pix_ready", pix_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_waddr", mem_waddr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_wr_ptr_gray", wr_ptr_gray, 0);
        check("rst_full", full, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_sync_err", sync_err, 0);
        m_wr = 0; m_rd_s1 = 0; m_rd_sync = 0;
        m_in_frame = 1'b0; m_pos = 0;
        e_we = 1'b0; e_done = 1'b0; e_err = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int guard;
        n_done = 0;
        @(posedge clk_write);
        #1;
        do_reset();
        $display("txn reset: outputs checked under reset");

        repeat (10) step(1'b1, 1'b0, 6'($urandom));
        $display("txn drain: 10 non-sof pixels presented before any sof");

        step(1'b1, 1'b1, 6'h2A);
        check("first_we", mem_we, 1);
        check("first_waddr", mem_waddr, 0);
        check("first_wdata", mem_wdata, 6'h2A);
        repeat (255) step(1'b1, 1'b0, 6'($urandom));
        check("gray_256", wr_ptr_gray, 10'h180);
        $display("txn line0: 256 pixels written, wr_ptr_gray=%0h", wr_ptr_gray);

        repeat (256) begin
            step(1'b1, 1'b0, 6'($urandom));
            if (m_wr == 507) check("afull_507", almost_full, 0);
            if (m_wr == 508) check("afull_508", almost_full, 1);
        end
        check("full_512", full, 1);
        check("ready_512", pix_ready, 0);
        $display("txn fill: 512 pixels written, full=%0b", full);

        m_rd_drive  = 1;
        rd_ptr_gray = to_gray(1);
        n = 0;
        do begin
            step(1'b1, 1'b0, 6'h15);
            n++;
        end while (!mem_we && n < 10);
        check("release_steps", n, 3);
        check("wrap_waddr", mem_waddr, 0);
        $display("txn release: pixel 513 written after %0d cycles", n);

        rd_mode = 1;
        repeat (530) step(1'b0, 1'b0, 6'h00);
        guard = 0;
        while (m_pos != 1000 && guard < 2000) begin
            step(1'b1, 1'b0, 6'($urandom));
            guard++;
        end
        step(1'b1, 1'b1, 6'h11);
        check("midframe_sync_err", sync_err, 1);
        $display("txn midsof: sof at pixel 1000, sync_err=%0b", sync_err);

        n_done = 0;
        repeat (FRAME_PIX - 1) step(1'b1, 1'b0, 6'($urandom));
        step(1'b1, 1'b0, 6'h07);
        check("frame_done_count", n_done, 1);
        check("drop_after_frame", mem_we, 0);
        check("sync_err_sticky", sync_err, 1);
        $display("txn frame: full frame completed, frame_done pulses=%0d", n_done);

        do_reset();
        check("sync_err_cleared", sync_err, 0);
        $display("txn reset2: sync_err=%0b", sync_err);

        rd_mode = 2;
        repeat (3000) step($urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0, 6'($urandom));
        $display("txn random: 3000 random cycles, %0d pixels written", m_wr);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nes_pixel_fifo_writer.md
Name: nes_pixel_fifo_writer

Overview:
- Write-side (producer end) of the NES video dual-clock pixel FIFO; lives entirely in the clk_write (CPU/PPU) domain.
- Accepts 6-bit NES colour codes from the PPU pixel stream with valid/ready flow control and aligns them to 256x240 frames using a start-of-frame marker.
- Drives the FIFO storage write port and exports a Gray-coded write pointer for the read (VGA) domain.
- Synchronises the read domain's Gray read pointer to compute full / almost-full backpressure.

Parameters:
- ADDR_W, 9, FIFO address width; depth = 2**ADDR_W = 512 entries.
- DATA_W, 6, colour code width.
- H_PIX, 256, pixels per line.
- V_LINES, 240, lines per frame.
- AFULL_MARGIN, 4, free entries remaining at which almost_full asserts.

Ports:
- clk_write  in  1  write-domain clock.
- reset  in  1  synchronous, active-high.
- pix_valid  in  1  PPU pixel valid.
- pix_code  in  DATA_W  NES colour code.
- pix_sof  in  1  qualifies pix_code as pixel (0,0) of a new frame.
- pix_ready  out  1  writer can accept the pixel this cycle.
- rd_ptr_gray  in  ADDR_W+1  Gray read pointer from the read domain; asynchronous to clk_write.
- mem_we  out  1  storage write enable.
- mem_waddr  out  ADDR_W  storage write address.
- mem_wdata  out  DATA_W  storage write data.
- wr_ptr_gray  out  ADDR_W+1  registered Gray write pointer, to the read domain.
- full  out  1  FIFO full.
- almost_full  out  1  occupancy >= 2**ADDR_W - AFULL_MARGIN.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.
- sync_err  out  1  sticky: sof was seen mid-frame.

Behaviour:
- Reset:
  - All outputs are 0: pix_ready, mem_we, mem_waddr, mem_wdata, wr_ptr_gray, full, almost_full, frame_done, sync_err.
  - Binary write pointer, both synchroniser stages, x counter and y counter are 0.
  - State is WAIT_SOF.
  - Reset asserted mid-frame discards the partial frame. No flush handshake; the read side is reset separately.
- Accept: a pixel is accepted when pix_valid && pix_ready.
- Write path, for a pixel written in cycle N:
  - mem_we=1, mem_waddr=old pointer[ADDR_W-1:0], mem_wdata=pix_code appear in cycle N+1 (registered).
  - The binary pointer and wr_ptr_gray advance at the same edge.
  - mem_we is 0 in any cycle not preceded by a written pixel.
- Pointer arithmetic:
  - Binary pointer is ADDR_W+1 bits, increments by 1 and wraps modulo 2**(ADDR_W+1).
  - wr_ptr_gray = bin ^ (bin >> 1), registered.
- Read-pointer synchroniser: rd_ptr_gray passes through 2 flops. rd_sync is the stage-2 output; rd_bin is its Gray-to-binary conversion.
- full = (wr_ptr_gray == {~rd_sync[ADDR_W:ADDR_W-1], rd_sync[ADDR_W-2:0]}). Combinational from registered values.
- Occupancy = (wr_bin - rd_bin) mod 2**(ADDR_W+1), range 0..2**ADDR_W.
- full and almost_full are conservative: stale by up to 3 cycles of read progress, never optimistic.
- State WAIT_SOF:
  - pix_ready = 1 (drain mode).
  - Accepted pixels with pix_sof=0 are dropped: no write, no counter change.
  - An accepted pixel with pix_sof=1 is written only if !full; in that case x=1, y=0, go to STREAM.
  - While full, pix_ready = !pix_sof, so a sof pixel stalls instead of being dropped.
- State STREAM:
  - pix_ready = !full. Each accepted pixel is written.
  - x increments; at x==H_PIX-1, x->0 and y increments.
  - When the pixel at (H_PIX-1, V_LINES-1) is written: frame_done=1 in the next cycle, x=y=0, go to WAIT_SOF.
- sof mid-frame (accepted in STREAM with pix_sof=1):
  - Set sync_err (cleared only by reset).
  - Write the pixel as (0,0) of a new frame, then x=1, y=0; stay in STREAM.
- Simultaneous events:
  - If full deasserts in the same cycle a pixel is presented, accept it.
  - A frame_done pulse and the next frame's sof acceptance may occur in the same cycle.

Decomposition:
- Package nes_video_pkg:
  - H_PIX/V_LINES defaults and the colour-code width.
  - typedef enum logic {WAIT_SOF, STREAM} wr_state_t.
  - Functions bin2gray and gray2bin (parameterised by width), shared with the read-side controller.
- Sub-module gray_ptr_sync: 2-flop synchroniser plus gray2bin output; reused by the read side.

Test Plan:
- Reset, then hold pix_valid=1, pix_sof=0 for 10 cycles -> pix_ready=1, mem_we stays 0, x=y=0, wr_ptr_gray=0.
- sof pixel code 0x2A, then 255 pixels, rd_ptr_gray static 0:
  - cycle after sof: mem_we=1, mem_waddr=0, mem_wdata=0x2A;
  - after 256 writes: wr_ptr_gray=bin2gray(256)=0x180, y=1.
- Stream 512 pixels with rd_ptr_gray=0 -> full=1 and pix_ready=0 after write 512. almost_full asserts after write 508. The 513th pixel is held. mem_waddr wraps 511->0 on that write only after the read pointer advances.
- With full=1, change rd_ptr_gray to gray(1) -> full deasserts exactly 2 cycles later (3rd clk_write edge counting the input change) and one pixel is accepted. Confirms synchroniser latency.
- Full 61440-pixel frame -> frame_done pulses exactly once, 1 cycle after the last write, state returns to WAIT_SOF. A pixel without sof is then dropped.
- sof at pixel 1000 of a frame -> sync_err=1 and stays 1. That pixel is written and counters restart at x=1, y=0. A later reset clears sync_err to 0.
